wb_sram_slave: RTL and testbench
================================

# wb_sram_slave

Pipelined Wishbone slave that serves memory requests from a bus master, for example the cache line fill/flush port, out of an external asynchronous 16-bit SRAM. Each 32-bit Wishbone word is split into two 16-bit SRAM phases with programmable wait states. The block handles one outstanding request at a time and applies back-pressure with `stall`.

## Interface
- `AWIDTH`, default 20: Wishbone byte-address width. SRAM half-word address is `AWIDTH-1` bits.
- `WAIT`, default 2: cycles per SRAM phase. Must be ≥2; elaborate-time error otherwise.
- `clk_i` in, 1: clock.
- `rst_i` in, 1: asynchronous, active-high reset.
- `bus` if_wb.slave, –: signals `cyc`, `stb`, `we`, `adr`, `sel[3:0]`, `dat` in/out (32), `ack`, `stall`. Port data is aliased the same way as the other wb blocks under `NO_MODPORT_EXPRESSIONS`.
- `sram_adr` out, AWIDTH-1: half-word address.
- `sram_dq_i` in, 16: read data from pads.
- `sram_dq_o` out, 16: write data.
- `sram_dq_oe` out, 1: pad output enable (tristate lives at top level).
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n` out, 1 each: active-low SRAM controls.

## Operation
- **States:** S_IDLE, S_LO, S_GAP, S_HI, S_ACK.
- **Accept:** in S_IDLE, `cyc & stb` (`stall`=0) latches `we`, `adr[AWIDTH-1:2]`, `sel`, `dat`.
  - The next state is S_LO, except for skip cases (see Configuration).
- **S_LO:** access half-word address `{adr[AWIDTH-1:2],1'b0}`, data `dat[15:0]`.
  - Write enables: `lb_n=~sel[0]`, `ub_n=~sel[1]`.
- **S_HI:** access half-word address `{…,1'b1}`, data `dat[31:16]`.
  - Write enables: `lb_n=~sel[2]`, `ub_n=~sel[3]`.
- **Reads:** always fetch both halves with `lb_n=ub_n=0`, ignoring `sel`.
- **Within a phase:**
  - `ce_n=0` and address stable for all WAIT cycles.
  - Writes: `dq_oe=1`, `we_n=0` for cycles 2..WAIT of the phase.
  - Reads: `oe_n=0` for all WAIT cycles; `sram_dq_i` is captured on the last cycle.
- **S_GAP:** one cycle with all strobes high and `dq_oe=0`, giving recovery between phases.
- **S_ACK:** `ack=1` for one cycle. On reads, `dat` holds the assembled word until the next read ack. Next state is S_IDLE.
- **Stall:** `stall=1` in every state except S_IDLE.
- **`cyc` dropped mid-access:** the SRAM sequence completes (no torn writes). `ack` is suppressed and the block returns to S_IDLE.
- **Reset:** asynchronous return to S_IDLE, even mid-write; `we_n` deasserts immediately.
- **Reset values:** `ack=0`, `stall=0`, `dat=0`, `sram_adr=0`, `sram_dq_o=0`, `sram_dq_oe=0`, all `*_n=1`.

## Timing
- All outputs are registered.
- Accept edge = cycle 0.
- S_LO = cycles 1..WAIT, S_GAP = WAIT+1, S_HI = WAIT+2..2·WAIT+1.
- Full access: `ack` at cycle 2·WAIT+2 (cycle 6 for WAIT=2).
- Single-phase write (skip enabled): `ack` at cycle WAIT+1. Zero-phase write: `ack` at cycle 1.
- Earliest next accept is the cycle after `ack`. Throughput is one word per 2·WAIT+3 cycles.
- Address and data are held through the phase's final cycle; `we_n` rises one cycle before the address may change.

## Configuration
- `WB_SRAM_SEL_SKIP_EN` defined:
  - A write phase whose two `sel` bits are both 0 is skipped, along with S_GAP.
  - `sel=0` on a write goes straight to S_ACK with no SRAM activity.
- Undefined: every write executes both phases; a phase with both `sel` bits 0 still asserts `ce_n`/`we_n` but with `lb_n=ub_n=1`.
- Reads are unaffected either way.

## Structure
- `wb_sram_pkg`: the `state_t` enum and localparams (phase count, half-word index bit).
- Single module; no sub-module is needed. The wait-state counter (`$clog2(WAIT+1)` bits) is inline.

## Test plan
- Write 0xDEADBEEF, adr 0x100, `sel`=F, WAIT=2 → SRAM model gets 0xBEEF @0x80 and 0xDEAD @0x81; `ack` at cycle 6; `we_n` low in cycles 2 and 5 only.
- Read adr 0x100 after the above → `dat`=0xDEADBEEF with `ack` at cycle 6; `oe_n` low cycles 1–2 and 4–5; `dq_oe` never set.
- Write 0x00AA0000, `sel`=4:
  - With EN: only the 0x81 phase runs with `lb_n=0`, `ub_n=1`; `ack` at cycle 3; memory 0x81 becomes 0xDEAA.
  - Without EN: `ack` at cycle 6, same memory result.
- Second `stb` presented during a busy access → `stall`=1 until after `ack`; the request is accepted the cycle after `ack`, and both complete in order.
- `cyc` dropped at cycle 3 of a write → both halves still written; no `ack`; the block returns to S_IDLE and accepts a new request.
- `rst_i` pulsed at cycle 2 of a write → all `*_n`=1 and `dq_oe`=0 asynchronously; `stall`=0 after release.

Source files
------------

// File: rtl/wb_sram_pkg.sv
// wb_sram_pkg: shared types and constants for the Wishbone-to-SRAM slave.
// Build option WB_SRAM_SEL_SKIP_EN: write phases with no byte selects are skipped.
package wb_sram_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_GAP,
        S_HI,
        S_ACK
    } state_t;

    // One 32-bit bus word maps onto two 16-bit SRAM half-words
    localparam int   NUM_PHASES = 2;
    localparam logic HW_LO      = 1'b0;
    localparam logic HW_HI      = 1'b1;

`ifdef WB_SRAM_SEL_SKIP_EN
    localparam bit SEL_SKIP = 1'b1;
`else
    localparam bit SEL_SKIP = 1'b0;
`endif

    // A phase touches the SRAM unless it is a write with no byte selected
    // and skipping is built in. Reads always run both phases.
    function automatic logic phase_runs(input logic we, input logic [1:0] sel2);
        return !SEL_SKIP || !we || (|sel2);
    endfunction

endpackage

// File: rtl/if_wb.sv
// if_wb: pipelined Wishbone bundle, 32-bit data with four byte selects.
// Data runs on two separate nets (dat_w master->slave, dat_r slave->master);
// blocks alias them to local names so no modport expressions are needed.
interface if_wb #(
    parameter int AW = 20
) ();
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [3:0]    sel;
    logic [31:0]   dat_w;
    logic [31:0]   dat_r;
    logic          ack;
    logic          stall;

    modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, stall);
    modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, stall);
endinterface

// File: rtl/wb_sram_slave.sv
// wb_sram_slave: pipelined Wishbone slave serving a 16-bit asynchronous SRAM.
// Each word is a low half-word phase, a one-cycle gap, then a high half-word
// phase, each WAIT cycles long; one request outstanding, back-pressure via stall.
// Build option WB_SRAM_SEL_SKIP_EN: skip write phases whose byte selects are zero.
module wb_sram_slave
    import wb_sram_pkg::*;
#(
    parameter int AWIDTH = 20,
    parameter int WAIT   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    if_wb.slave               bus,
    output logic [AWIDTH-2:0] sram_adr,
    input  logic [15:0]       sram_dq_i,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    localparam int CW = $clog2(WAIT + 1);
    localparam int WW = AWIDTH - 2;

    if (WAIT < 2) begin : g_bad_wait
        $error("wb_sram_slave: WAIT must be at least 2");
    end

    // Bus data aliased to local names; outputs driven from registers
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        ack_q;
    logic        stall_q;

    assign wb_dat_i  = bus.dat_w;
    assign bus.dat_r = wb_dat_o;
    assign bus.ack   = ack_q;
    assign bus.stall = stall_q;

    // Byte offset within the word is meaningless to a word-wide slave
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^bus.adr[1:0];

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            we_q, keep_q;
    logic [WW-1:0]   adr_q;
    logic [3:0]      sel_q;
    logic [31:0]     wdat_q;
    logic [15:0]     rd_lo;

    logic            accept, last;
    logic            we_v, keep_v, lo_run, hi_run;
    logic [WW-1:0]   adr_v;
    logic [3:0]      sel_v;
    logic [31:0]     wdat_v;

    logic            in_ph, hi_ph;
    logic [1:0]      sel2;
    logic [WW:0]     adr_nx;
    logic [15:0]     dq_nx;
    logic            dq_oe_nx, ce_nx, oe_nx, we_nx, lb_nx, ub_nx;
    logic            ack_nx, stall_nx, rd_load;

    assign accept = (state == S_IDLE) && bus.cyc && bus.stb;
    assign last   = (cnt == CW'(WAIT));

    // Request fields as they will be after this edge (fresh on accept)
    assign we_v   = accept ? bus.we              : we_q;
    assign adr_v  = accept ? bus.adr[AWIDTH-1:2] : adr_q;
    assign sel_v  = accept ? bus.sel             : sel_q;
    assign wdat_v = accept ? wb_dat_i            : wdat_q;
    assign lo_run = phase_runs(we_v, sel_v[1:0]);
    assign hi_run = phase_runs(we_v, sel_v[3:2]);

    // Master still wants the answer: cleared for good once cyc drops mid-access
    assign keep_v = (accept || keep_q) && bus.cyc;

    // Next state, wait counter, and next values of all registered outputs
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    cnt_n = CW'(1);
                    if (lo_run)      state_n = S_LO;
                    else if (hi_run) state_n = S_HI;
                    else             state_n = S_ACK;
                end
            end
            S_LO: begin
                if (last) state_n = hi_run ? S_GAP : S_ACK;
                else      cnt_n   = cnt + CW'(1);
            end
            S_GAP: begin
                state_n = S_HI;
                cnt_n   = CW'(1);
            end
            S_HI: begin
                if (last) state_n = S_ACK;
                else      cnt_n   = cnt + CW'(1);
            end
            S_ACK:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        in_ph = (state_n == S_LO) || (state_n == S_HI);
        hi_ph = (state_n == S_HI);
        sel2  = hi_ph ? sel_v[3:2] : sel_v[1:0];

        // Address and write data hold outside phases so they stay stable past we_n
        adr_nx   = in_ph ? {adr_v, (hi_ph ? HW_HI : HW_LO)} : sram_adr;
        dq_nx    = (in_ph && we_v) ? (hi_ph ? wdat_v[31:16] : wdat_v[15:0]) : sram_dq_o;
        ce_nx    = !in_ph;
        oe_nx    = !(in_ph && !we_v);
        // Write strobe skips the first phase cycle so address settles first
        we_nx    = !(in_ph && we_v && (cnt_n >= CW'(2)));
        dq_oe_nx = !we_nx;
        lb_nx    = !(in_ph && (!we_v || sel2[0]));
        ub_nx    = !(in_ph && (!we_v || sel2[1]));

        ack_nx   = (state_n == S_ACK) && keep_v;
        stall_nx = (state_n != S_IDLE);
        rd_load  = ack_nx && !we_v;
    end

    // FSM state and wait-state counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Request capture, abort tracking and low half-word read capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q   <= 1'b0;
            adr_q  <= '0;
            sel_q  <= '0;
            wdat_q <= '0;
            keep_q <= 1'b0;
            rd_lo  <= '0;
        end else begin
            if (accept) begin
                we_q   <= bus.we;
                adr_q  <= bus.adr[AWIDTH-1:2];
                sel_q  <= bus.sel;
                wdat_q <= wb_dat_i;
            end
            keep_q <= keep_v;
            if (state == S_LO && last && !we_q) rd_lo <= sram_dq_i;
        end
    end

    // Registered bus and SRAM pins; reset parks every strobe inactive
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q      <= 1'b0;
            stall_q    <= 1'b0;
            wb_dat_o   <= '0;
            sram_adr   <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
        end else begin
            ack_q      <= ack_nx;
            stall_q    <= stall_nx;
            if (rd_load) wb_dat_o <= {sram_dq_i, rd_lo};
            sram_adr   <= adr_nx;
            sram_dq_o  <= dq_nx;
            sram_dq_oe <= dq_oe_nx;
            sram_ce_n  <= ce_nx;
            sram_oe_n  <= oe_nx;
            sram_we_n  <= we_nx;
            sram_lb_n  <= lb_nx;
            sram_ub_n  <= ub_nx;
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave: directed plus random Wishbone traffic against a byte-lane
// memory reference model and a cycle-level view of the SRAM strobes.
module tb_wb_sram_slave;

    localparam int W  = 2;
    localparam int AW = 20;
`ifdef WB_SRAM_SEL_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    if_wb #(.AW(AW)) bus_if ();

    logic [AW-2:0] sram_adr;
    logic [15:0]   sram_dq_i, sram_dq_o;
    logic          sram_dq_oe, ce_n, oe_n, we_n, lb_n, ub_n;

    wb_sram_slave #(.AWIDTH(AW), .WAIT(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus_if),
        .sram_adr   (sram_adr),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (ce_n),
        .sram_oe_n  (oe_n),
        .sram_we_n  (we_n),
        .sram_lb_n  (lb_n),
        .sram_ub_n  (ub_n)
    );

    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];
    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 40503 + 12345);
    endfunction

    // Asynchronous SRAM pad model: reads are combinational, garbage when not enabled
    assign sram_dq_i = (!ce_n && !oe_n) ? mem[sram_adr[7:0]] : 16'hA5C3;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        end else if (!ce_n && !we_n) begin
            if (!lb_n) mem[sram_adr[7:0]][7:0]  = sram_dq_o[7:0];
            if (!ub_n) mem[sram_adr[7:0]][15:8] = sram_dq_o[15:8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int hw_base(input logic [AW-1:0] adr);
        return ((int'(adr) >> 2) * 2) & 255;
    endfunction

    task automatic ref_write(input logic [AW-1:0] adr, input logic [3:0] sel, input logic [31:0] wd);
        int b;
        b = hw_base(adr);
        for (int i = 0; i < 4; i++)
            if (sel[i]) ref_mem[b + i / 2][(i % 2) * 8 +: 8] = wd[i * 8 +: 8];
    endtask

    function automatic logic [31:0] ref_read(input logic [AW-1:0] adr);
        int b;
        b = hw_base(adr);
        return {ref_mem[b + 1], ref_mem[b]};
    endfunction

    function automatic int n_phases(input logic we, input logic [3:0] sel);
        if (!we || !SKIP) return 2;
        return int'(|sel[1:0]) + int'(|sel[3:2]);
    endfunction

    function automatic int exp_lat(input logic we, input logic [3:0] sel);
        int n;
        n = n_phases(we, sel);
        return (n == 2) ? 2 * W + 2 : (n == 1) ? W + 1 : 1;
    endfunction

    // Write strobe in cycles 2..W of each executed phase (phase 2 starts at W+2)
    function automatic logic [31:0] exp_we_mask(input logic we, input logic [3:0] sel);
        logic [31:0] m;
        int s;
        m = '0;
        if (we)
            for (int p = 0; p < n_phases(we, sel); p++) begin
                s = (p == 0) ? 1 : W + 2;
                for (int c = 2; c <= W; c++) m[s + c - 1] = 1'b1;
            end
        return m;
    endfunction

    function automatic logic [31:0] exp_oe_mask(input logic we);
        logic [31:0] m;
        m = '0;
        if (!we)
            for (int p = 0; p < 2; p++)
                for (int c = 1; c <= W; c++) m[((p == 0) ? 1 : W + 2) + c - 1] = 1'b1;
        return m;
    endfunction

    // ---------------- bus driver ----------------
    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!bus_if.stall) begin ok = 1'b1; break; end
        end
        chk("accept", 32'(ok), 32'd1);
    endtask

    // Observe cycles 1.. after the accept edge until ack
    task automatic collect(output logic [31:0] rd, output int lat,
                           output logic [31:0] wm, output logic [31:0] om, output logic [31:0] dm);
        bit got;
        got = 1'b0; wm = '0; om = '0; dm = '0; lat = 0; rd = '0;
        for (int n = 1; n < 30; n++) begin
            @(negedge clk);
            if (!we_n)      wm[n] = 1'b1;
            if (!oe_n)      om[n] = 1'b1;
            if (sram_dq_oe) dm[n] = 1'b1;
            if (bus_if.ack) begin lat = n; rd = bus_if.dat_r; got = 1'b1; break; end
        end
        chk("ack_seen", 32'(got), 32'd1);
    endtask

    task automatic present(input logic we, input logic [AW-1:0] adr, input logic [3:0] sel, input logic [31:0] wd);
        bus_if.cyc = 1'b1; bus_if.stb = 1'b1; bus_if.we = we;
        bus_if.adr = adr;  bus_if.sel = sel;  bus_if.dat_w = wd;
    endtask

    task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [3:0] sel, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat,
                           output logic [31:0] wm, output logic [31:0] om, output logic [31:0] dm);
        @(posedge clk); #1;
        present(we, adr, sel, wd);
        wait_accept();
        @(posedge clk); #1;
        bus_if.stb = 1'b0;
        collect(rd, lat, wm, om, dm);
        bus_if.cyc = 1'b0;
    endtask

    task automatic txn_check(input string tag, input logic we, input logic [AW-1:0] adr,
                             input logic [3:0] sel, input logic [31:0] wd, output logic [31:0] rd, output int lat);
        logic [31:0] wm, om, dm;
        run_txn(we, adr, sel, wd, rd, lat, wm, om, dm);
        chk({tag, "_lat"},   32'(lat), 32'(exp_lat(we, sel)));
        chk({tag, "_we_n"},  wm, exp_we_mask(we, sel));
        chk({tag, "_oe_n"},  om, exp_oe_mask(we));
        chk({tag, "_dq_oe"}, dm, exp_we_mask(we, sel));
        if (we) ref_write(adr, sel, wd);
        else    chk({tag, "_rdat"}, rd, ref_read(adr));
    endtask

    initial begin
        logic [31:0] rd;
        int lat, stalled, acks;
        logic rw;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        bus_if.cyc = 1'b0; bus_if.stb = 1'b0; bus_if.we = 1'b0;
        bus_if.adr = '0;   bus_if.sel = '0;   bus_if.dat_w = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",   32'(bus_if.ack),   32'd0);
        chk("rst_stall", 32'(bus_if.stall), 32'd0);
        chk("rst_dat",   bus_if.dat_r,      32'd0);
        chk("rst_adr",   32'(sram_adr),     32'd0);
        chk("rst_dq_o",  32'(sram_dq_o),    32'd0);
        chk("rst_dq_oe", 32'(sram_dq_oe),   32'd0);
        chk("rst_strb",  32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1f);
        mem_init = 1'b0;
        rst = 1'b0;

        // Full write, then read it back
        txn_check("wr1", 1'b1, 20'h100, 4'hF, 32'hDEADBEEF, rd, lat);
        chk("wr1_ack6", 32'(lat), 32'd6);
        chk("wr1_m80", 32'(mem[8'h80]), 32'h0000BEEF);
        chk("wr1_m81", 32'(mem[8'h81]), 32'h0000DEAD);
        txn_check("rd1", 1'b0, 20'h100, 4'h0, 32'h0, rd, lat);
        chk("rd1_dat", rd, 32'hDEADBEEF);

        // Single upper byte in the high half
        txn_check("wr4", 1'b1, 20'h100, 4'h4, 32'h00AA0000, rd, lat);
        chk("wr4_ack", 32'(lat), SKIP ? 32'd3 : 32'd6);
        chk("wr4_m81", 32'(mem[8'h81]), 32'h0000DEAA);
        chk("wr4_m80", 32'(mem[8'h80]), 32'h0000BEEF);

        // No byte selected at all
        txn_check("wr0", 1'b1, 20'h104, 4'h0, 32'h12121212, rd, lat);
        chk("wr0_ack", 32'(lat), SKIP ? 32'd1 : 32'd6);

        // Second request held against stall while the first is busy
        @(posedge clk); #1;
        present(1'b1, 20'h80, 4'hF, 32'h0BADF00D);
        wait_accept();
        @(posedge clk); #1;
        bus_if.we = 1'b0;
        stalled = 0; lat = 0;
        for (int n = 1; n < 30; n++) begin
            @(negedge clk);
            if (bus_if.stall) stalled++;
            if (bus_if.ack) begin lat = n; break; end
        end
        chk("b2b_latA",  32'(lat),     32'(2 * W + 2));
        chk("b2b_stall", 32'(stalled), 32'(lat));
        ref_write(20'h80, 4'hF, 32'h0BADF00D);
        @(negedge clk);
        chk("b2b_free", 32'(bus_if.stall), 32'd0);
        @(posedge clk); #1;
        bus_if.stb = 1'b0;
        begin
            logic [31:0] wm, om, dm;
            collect(rd, lat, wm, om, dm);
        end
        bus_if.cyc = 1'b0;
        chk("b2b_latB", 32'(lat), 32'(2 * W + 2));
        chk("b2b_rdB",  rd, 32'h0BADF00D);

        // cyc dropped in cycle 3 of a write: both halves land, no ack
        @(posedge clk); #1;
        present(1'b1, 20'h40, 4'hF, 32'h12345678);
        wait_accept();
        @(posedge clk); #1; bus_if.stb = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; bus_if.cyc = 1'b0;
        acks = 0;
        repeat (2 * W + 6) begin
            @(negedge clk);
            if (bus_if.ack) acks++;
        end
        chk("drop_noack", 32'(acks), 32'd0);
        chk("drop_idle",  32'(bus_if.stall), 32'd0);
        ref_write(20'h40, 4'hF, 32'h12345678);
        chk("drop_m20", 32'(mem[8'h20]), 32'h00005678);
        chk("drop_m21", 32'(mem[8'h21]), 32'h00001234);
        txn_check("drop_rd", 1'b0, 20'h40, 4'h0, 32'h0, rd, lat);

        // Asynchronous reset in cycle 2 of a write
        @(posedge clk); #1;
        present(1'b1, 20'h60, 4'hF, 32'hCAFEF00D);
        wait_accept();
        @(posedge clk); #1; bus_if.stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_we", 32'(we_n), 32'd0);
        #1 rst = 1'b1; bus_if.cyc = 1'b0;
        #1;
        chk("arst_strb",  32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1f);
        chk("arst_dq_oe", 32'(sram_dq_oe), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("arst_stall", 32'(bus_if.stall), 32'd0);
        chk("arst_ack",   32'(bus_if.ack),   32'd0);

        // Random mix of reads and writes against the reference model
        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            txn_check("rnd", rw, AW'($urandom_range(0, 127) << 2), 4'($urandom_range(0, 15)), $urandom, rd, lat);
        end

        // Whole SRAM image against the reference
        for (int i = 0; i < 256; i++) chk("mem_sweep", 32'(mem[i]), 32'(ref_mem[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
